// File: rtl/seq_alu_display.sv
// Multi-cycle signed ALU (add/sub, shift-add multiply, restoring divide) with double-dabble
// BCD readout on active-low 7-segment digits. Define SEQ_ALU_DIVIDE_EN to build the divider.
module seq_alu_display #(
  parameter int WIDTH  = 6,
  parameter int N_SEGS = 8,
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           func,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   leds,
  output logic [0:7*N_SEGS-1]  segs,
  output logic                 err,
  output logic [1:0]           state_dbg
);
  // Handshake: start is a request sampled only in IDLE; busy covers EXEC..DONE; done marks the
  // single cycle in which leds/segs/err first carry the new result.
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(RW + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_CONV = CW'(RW);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic [RW-1:0]       acc_q, acc_d;
  logic [RW-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]    shf_q, shf_d;
  logic [RW-1:0]       wres_q, wres_d;
  logic                werr_q, werr_d, wneg_q, wneg_d;
  logic [RW-1:0]       bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [RW-1:0]       res_q, res_d;
  logic                err_q, err_d;
  logic [RW-1:0]       leds_q, leds_d;
  logic [0:7*N_SEGS-1] segs_q, segs_d;

  logic [WIDTH-1:0]    mag_a_in, mag_b_in;
  logic                sgn_diff, ferr, last_exec, show;
  logic [RW-1:0]       fres, disp, mag_disp, bin_sh;
  logic [BW-1:0]       bcd_adj, bcd_sh;
  logic [6:0]          pat;
`ifdef SEQ_ALU_DIVIDE_EN
  logic [WIDTH-1:0]    rem_q, rem_d, mag_b, quo, rem;
  logic [WIDTH:0]      rsh;
`endif

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
    mag_of = v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [6:0] seg_on(input logic [3:0] d);
    case (d)
      4'd0: seg_on = 7'h3F;
      4'd1: seg_on = 7'h06;
      4'd2: seg_on = 7'h5B;
      4'd3: seg_on = 7'h4F;
      4'd4: seg_on = 7'h66;
      4'd5: seg_on = 7'h6D;
      4'd6: seg_on = 7'h7D;
      4'd7: seg_on = 7'h07;
      4'd8: seg_on = 7'h7F;
      4'd9: seg_on = 7'h6F;
      default: seg_on = 7'h00;
    endcase
  endfunction

  // Signed result, error flag and display value, valid once EXEC has finished.
  always_comb begin
    sgn_diff = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    fres     = acc_q;
    ferr     = 1'b0;
    disp     = acc_q;
`ifdef SEQ_ALU_DIVIDE_EN
    mag_b = mag_of(b_q);
    rsh   = {rem_q, shf_q[WIDTH-1]};
    quo   = sgn_diff ? -shf_q : shf_q;
    rem   = a_q[WIDTH-1] ? -rem_q : rem_q;
`endif
    case (op_q)
      2'b10: begin
        fres = sgn_diff ? -acc_q : acc_q;
        disp = fres;
      end
      2'b11: begin
`ifdef SEQ_ALU_DIVIDE_EN
        if (b_q == '0) begin
          fres = {a_q, {WIDTH{1'b0}}};
          ferr = 1'b1;
        end else begin
          fres = {rem, quo};
          ferr = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        end
        disp = {{WIDTH{fres[WIDTH-1]}}, fres[WIDTH-1:0]};
`else
        fres = '0;
        ferr = 1'b1;
        disp = '0;
`endif
      end
      default: ;
    endcase
    mag_disp = disp[RW-1] ? -disp : disp;

    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    {bcd_sh, bin_sh} = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    shf_d   = shf_q;
    wres_d  = wres_q;
    werr_d  = werr_q;
    wneg_d  = wneg_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
`ifdef SEQ_ALU_DIVIDE_EN
    rem_d   = rem_q;
`endif
    mag_a_in  = mag_of(a);
    mag_b_in  = mag_of(b);
    last_exec = (op_q[1] == 1'b0) ? 1'b1 : (cnt_q == CNT_ITER);
`ifndef SEQ_ALU_DIVIDE_EN
    if (op_q == 2'b11) last_exec = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXEC;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          op_d    = func[1:0];
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, mag_b_in};
          shf_d   = mag_a_in;
`ifdef SEQ_ALU_DIVIDE_EN
          rem_d   = '0;
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          2'b00: acc_d = {{WIDTH{a_q[WIDTH-1]}}, a_q} + {{WIDTH{b_q[WIDTH-1]}}, b_q};
          2'b01: acc_d = {{WIDTH{a_q[WIDTH-1]}}, a_q} - {{WIDTH{b_q[WIDTH-1]}}, b_q};
          2'b10: begin
            if (shf_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            shf_d   = shf_q >> 1;
          end
          default: begin
`ifdef SEQ_ALU_DIVIDE_EN
            // Restoring step: shf_q holds the remaining dividend bits and gathers quotient bits.
            if (rsh >= {1'b0, mag_b}) begin
              rem_d = rsh[WIDTH-1:0] - mag_b;
              shf_d = {shf_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = rsh[WIDTH-1:0];
              shf_d = {shf_q[WIDTH-2:0], 1'b0};
            end
`endif
          end
        endcase
        if (last_exec) begin
          state_d = S_CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONV: begin
        // Count 0 captures the result; counts 1..RW are the double-dabble shifts.
        if (cnt_q == '0) begin
          wres_d = fres;
          werr_d = ferr;
          wneg_d = disp[RW-1];
          bin_d  = mag_disp;
          bcd_d  = '0;
        end else begin
          bcd_d = bcd_sh;
          bin_d = bin_sh;
        end
        if (cnt_q == CNT_CONV) state_d = S_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_d  = res_q;
    err_d  = err_q;
    segs_d = segs_q;
    show   = 1'b0;
    pat    = '0;
    if (state_q == S_CONV && cnt_q == CNT_CONV) begin
      res_d  = wres_q;
      err_d  = werr_q;
      segs_d = '1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
        show = show | (bcd_sh[4*k +: 4] != 4'd0) | (k == 0);
        pat  = seg_on(bcd_sh[4*k +: 4]);
        if (show)
          for (int s = 0; s < 7; s++) segs_d[7*k + s] = ~pat[s];
      end
      segs_d[7*DIGITS + 6] = ~wneg_q;
    end
    leds_d = func[2] ? {a, b} : res_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      shf_q   <= '0;
      wres_q  <= '0;
      werr_q  <= 1'b0;
      wneg_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      leds_q  <= '0;
      segs_q  <= '1;
`ifdef SEQ_ALU_DIVIDE_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      shf_q   <= shf_d;
      wres_q  <= wres_d;
      werr_q  <= werr_d;
      wneg_q  <= wneg_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      res_q   <= res_d;
      err_q   <= err_d;
      leds_q  <= leds_d;
      segs_q  <= segs_d;
`ifdef SEQ_ALU_DIVIDE_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign leds      = leds_q;
  assign segs      = segs_q;
  assign err       = err_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_seq_alu_display.sv
// Bench for seq_alu_display: cycle-level behavioural model (integer arithmetic, decimal digits),
// per-cycle compare process, directed literal checks and randomized per-cycle stimulus.
module tb_seq_alu_display;
  localparam int W  = 6;
  localparam int NS = 8;
  localparam int DG = 4;
  localparam int RW = 2 * W;
`ifdef SEQ_ALU_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, start;
  logic [W-1:0]    a, b;
  logic [2:0]      func;
  logic            busy, done, err;
  logic [RW-1:0]   leds;
  logic [0:7*NS-1] segs;
  logic [1:0]      state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Active-high patterns, bit 0 = segment a.
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seq_alu_display #(.WIDTH(W), .N_SEGS(NS), .DIGITS(DG)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .func(func), .start(start),
    .busy(busy), .done(done), .leds(leds), .segs(segs), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic int lat_of(input logic [1:0] op);
    if (op == 2'b10 || (op == 2'b11 && DIV_EN)) return W + RW + 1;
    return 1 + RW + 1;
  endfunction

  function automatic void model_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] op,
                                   output logic [RW-1:0] res, output logic er, output int disp);
    int sa, sb, q, r, v;
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    er = 1'b0;
    case (op)
      2'b00:   v = sa + sb;
      2'b01:   v = sa - sb;
      2'b10:   v = sa * sb;
      default: v = 0;
    endcase
    res  = RW'(v);
    disp = v;
    if (op == 2'b11) begin
      if (!DIV_EN) begin
        res = '0; er = 1'b1; disp = 0;
      end else begin
        if (sb == 0) begin q = 0; r = sa; er = 1'b1; end
        else begin q = sa / sb; r = sa % sb; end
        if (q == 2 ** (W - 1)) begin q = -(2 ** (W - 1)); er = 1'b1; end
        res  = {W'(r), W'(q)};
        disp = q;
      end
    end
  endfunction

  function automatic logic [0:7*NS-1] model_segs(input int disp);
    logic [0:7*NS-1] o;
    int mag, p, d;
    o   = '1;
    mag = (disp < 0) ? -disp : disp;
    p   = 1;
    for (int k = 0; k < DG; k++) begin
      if (k == 0 || mag >= p) begin
        d = (mag / p) % 10;
        for (int s = 0; s < 7; s++) o[7*k + s] = ~seg_tab[d][s];
      end
      p = p * 10;
    end
    if (disp < 0) o[7*DG + 6] = 1'b0;
    return o;
  endfunction

  function automatic logic [6:0] dig(input int k);
    logic [6:0] d;
    for (int s = 0; s < 7; s++) d[s] = segs[7*k + s];
    return d;
  endfunction

  // Model: m_left = busy cycles still to come; the DONE cycle is the one with m_left == 1.
  int              m_left = 0;
  bit              m_valid = 1'b0;
  logic [RW-1:0]   m_res, p_res, m_leds;
  logic            m_err, p_err;
  logic [0:7*NS-1] m_segs, p_segs;
  int              p_disp;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_res = '0; m_err = 1'b0; m_segs = '1; m_leds = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_left == 0) begin
        if (start) begin
          model_op(a, b, func[1:0], p_res, p_err, p_disp);
          p_segs = model_segs(p_disp);
          m_left = lat_of(func[1:0]) + 1;
        end
      end else begin
        m_left--;
        if (m_left == 1) begin
          m_res = p_res; m_err = p_err; m_segs = p_segs;
        end
      end
      m_leds = func[2] ? {a, b} : m_res;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", busy, m_left != 0);
      check("done", done, m_left == 1);
      check("leds", leds, m_leds);
      check("err", err, m_err);
      check("segs", segs, m_segs);
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] tf,
                        input int exp_l);
    int n;
    @(negedge clk);
    a = ta; b = tb; func = tf; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 60 && !done) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_l);
  endtask

  initial begin
    int dcount, dlat;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; func = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_leds", leds, 12'h000);
    check("rst_segs", segs, {56{1'b1}});
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    run_op(6'd31, 6'd31, 3'b000, 14);
    check("add_leds", leds, 12'h03E);
    check("add_d1", dig(1), 7'h02);
    check("add_d0", dig(0), 7'h24);
    check("add_d2", dig(2), 7'h7F);
    check("add_d4", dig(4), 7'h7F);
    check("add_err", err, 1'b0);

    run_op(6'(-32), 6'd31, 3'b001, 14);
    check("sub_leds", leds, 12'hFC1);
    check("sub_d4", dig(4), 7'h3F);
    check("sub_d3", dig(3), 7'h7F);
    check("sub_d2", dig(2), 7'h7F);
    check("sub_d1", dig(1), 7'h02);
    check("sub_d0", dig(0), 7'h30);

    run_op(6'(-32), 6'(-32), 3'b010, 19);
    check("mul_leds", leds, 12'h400);
    check("mul_d3", dig(3), 7'h79);
    check("mul_d2", dig(2), 7'h40);
    check("mul_d1", dig(1), 7'h24);
    check("mul_d0", dig(0), 7'h19);
    check("mul_err", err, 1'b0);

    run_op(6'(-1), 6'd31, 3'b010, 19);
    check("mul2_leds", leds, 12'hFE1);
    check("mul2_d4", dig(4), 7'h3F);
    check("mul2_d2", dig(2), 7'h7F);
    check("mul2_d1", dig(1), 7'h30);
    check("mul2_d0", dig(0), 7'h79);

`ifdef SEQ_ALU_DIVIDE_EN
    run_op(6'(-17), 6'd5, 3'b011, 19);
    check("div_leds", leds, 12'hFBD);
    check("div_d4", dig(4), 7'h3F);
    check("div_d1", dig(1), 7'h7F);
    check("div_d0", dig(0), 7'h30);
    check("div_err", err, 1'b0);
    run_op(6'd7, 6'd0, 3'b011, 19);
    check("div0_leds", leds, 12'h1C0);
    check("div0_err", err, 1'b1);
    check("div0_d0", dig(0), 7'h40);
    run_op(6'(-32), 6'(-1), 3'b011, 19);
    check("dovf_err", err, 1'b1);
    check("dovf_leds", leds, 12'h020);
    check("dovf_d4", dig(4), 7'h3F);
    check("dovf_d1", dig(1), 7'h30);
    check("dovf_d0", dig(0), 7'h24);
`else
    run_op(6'd9, 6'd3, 3'b011, 14);
    check("nodiv_err", err, 1'b1);
    check("nodiv_leds", leds, 12'h000);
    check("nodiv_d0", dig(0), 7'h40);
    check("nodiv_d1", dig(1), 7'h7F);
`endif

    // Second start mid-multiply must be ignored.
    @(negedge clk);
    a = 6'd3; b = 6'd4; func = 3'b010; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dcount = 0; dlat = -1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin dcount++; dlat = i; end
      if (i == 4) begin start = 1'b1; a = 6'd7; b = 6'd7; end
      if (i == 5) start = 1'b0;
      @(negedge clk);
    end
    check("ign_count", dcount, 1);
    check("ign_lat", dlat, 19);
    check("ign_leds", leds, 12'd12);
    check("ign_d1", dig(1), 7'h79);
    check("ign_d0", dig(0), 7'h24);

    // Reset in the middle of a multiply.
    @(negedge clk);
    a = 6'd5; b = 6'd6; func = 3'b010; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 1'b0);
    check("mrst_segs", segs, {56{1'b1}});
    check("mrst_leds", leds, 12'h000);
    rst = 1'b0;
    run_op(6'd1, 6'd2, 3'b000, 14);
    check("add3_leds", leds, 12'h003);
    check("add3_d0", dig(0), 7'h30);
    check("add3_d1", dig(1), 7'h7F);

    // Reset together with start: nothing accepted.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 6'd1; b = 6'd1; func = 3'b000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rststart_busy", busy, 1'b0);

    // Live LED view while idle.
    func = 3'b100; a = 6'd5; b = 6'(-1);
    @(negedge clk);
    check("view_leds", leds, 12'h17F);
    func = 3'b000;
    @(negedge clk);
    check("view_off", leds, 12'h000);

    // Randomized per-cycle stimulus; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a     = ($urandom_range(0, 9) == 0) ? 6'h20 : W'($urandom);
      b     = ($urandom_range(0, 9) == 0) ? 6'h00 : W'($urandom);
      if ($urandom_range(0, 19) == 0) b = 6'h3F;
      func  = 3'($urandom);
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (25) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
